// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the 16-bit single-cycle CPU.
//   ADDR_WIDTH : width of the instruction address bus (word addressed)
//   PC_INCR    : default program-counter step, one instruction per address
//   addr_t     : instruction address type
package cpu_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int PC_INCR    = 1;

    typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage : cpu_pkg

// File: rtl/pc_incr_comb.sv
// pc_incr_comb
// Purely combinational program-counter adder. Adds a fixed increment to the
// incoming address using an ADDR_WIDTH+1 bit unsigned sum.
// Ports:
//   addr  (in,  ADDR_WIDTH) : current program counter
//   sum   (out, ADDR_WIDTH) : low bits of addr + PC_INCR (modulo 2^ADDR_WIDTH)
//   carry (out, 1)          : carry out of the addition, i.e. address wrap
module pc_incr_comb
    import cpu_pkg::*;
#(
    parameter int          ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
    parameter int unsigned PC_INCR    = cpu_pkg::PC_INCR
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [ADDR_WIDTH-1:0] sum,
    output logic                  carry
);

    // The increment is truncated to the address width before the add, so an
    // oversized PC_INCR behaves as its modulo-2^ADDR_WIDTH value.
    localparam logic [ADDR_WIDTH-1:0] INCR_C = ADDR_WIDTH'(PC_INCR);

    logic [ADDR_WIDTH:0] full_sum;

    always_comb begin
        full_sum = {1'b0, addr} + {1'b0, INCR_C};
        sum      = full_sum[ADDR_WIDTH-1:0];
        carry    = full_sum[ADDR_WIDTH];
    end

endmodule : pc_incr_comb

// File: rtl/pc_adder.sv
// pc_adder
// Program-counter incrementer. Every rising clock edge it registers
// current_address + PC_INCR as the sequential fetch address, together with a
// flag telling whether the addition wrapped past the top of the address space.
// Ports:
//   clk             (in,  1)          : system clock, rising edge
//   reset           (in,  1)          : asynchronous, active-high reset
//   current_address (in,  ADDR_WIDTH) : PC of the instruction being executed
//   next_address    (out, ADDR_WIDTH) : registered current_address + PC_INCR
//   wrapped         (out, 1)          : registered carry out of that addition
module pc_adder
    import cpu_pkg::*;
#(
    parameter int          ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
    parameter int unsigned PC_INCR    = cpu_pkg::PC_INCR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] current_address,
    output logic [ADDR_WIDTH-1:0] next_address,
    output logic                  wrapped
);

    logic [ADDR_WIDTH-1:0] sum;
    logic                  carry;

    logic [ADDR_WIDTH-1:0] next_address_d;
    logic [ADDR_WIDTH-1:0] next_address_q;
    logic                  wrapped_d;
    logic                  wrapped_q;

    pc_incr_comb #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .PC_INCR    (PC_INCR)
    ) u_incr (
        .addr  (current_address),
        .sum   (sum),
        .carry (carry)
    );

    // No enable or stall: the register simply reloads the adder result
    // on every edge.
    always_comb begin
        next_address_d = sum;
        wrapped_d      = carry;
    end

    // Reset clears the outputs immediately and discards any pending sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            next_address_q <= '0;
            wrapped_q      <= 1'b0;
        end else begin
            next_address_q <= next_address_d;
            wrapped_q      <= wrapped_d;
        end
    end

    assign next_address = next_address_q;
    assign wrapped      = wrapped_q;

endmodule : pc_adder

// File: tb/tb_pc_adder.sv
// tb_pc_adder
// Directed testbench for pc_adder. One instance uses the default increment
// of 1, a second instance uses PC_INCR = 2; both share clock, reset and
// address input. Expected values are hand-computed constants.
module tb_pc_adder;

    logic        clk;
    logic        reset;
    logic [15:0] current_address;
    logic [15:0] next_address;
    logic        wrapped;
    logic [15:0] next_address_2;
    logic        wrapped_2;

    int check_count;
    int error_count;

    pc_adder dut (
        .clk             (clk),
        .reset           (reset),
        .current_address (current_address),
        .next_address    (next_address),
        .wrapped         (wrapped)
    );

    pc_adder #(
        .ADDR_WIDTH (16),
        .PC_INCR    (2)
    ) dut_incr2 (
        .clk             (clk),
        .reset           (reset),
        .current_address (current_address),
        .next_address    (next_address_2),
        .wrapped         (wrapped_2)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compares one observed value with its expected value; 4-state compare
    // so X/Z on an output is reported as a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drives a new address on the falling edge, then waits until just after
    // the next rising edge so the registered result can be sampled.
    task automatic applyStimulus(input logic [15:0] addr);
        @(negedge clk);
        current_address = addr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        check_count     = 0;
        error_count     = 0;
        reset           = 1'b1;
        current_address = 16'h1234;

        // Reset held across two edges keeps the outputs at zero.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_addr", 32'(next_address), 32'h0000);
        checkOutput("reset_wrap", 32'(wrapped), 32'h0);
        checkOutput("reset_addr_i2", 32'(next_address_2), 32'h0000);

        // Release between edges; first edge loads 0 + 1.
        @(negedge clk);
        reset           = 1'b0;
        current_address = 16'h0000;
        @(posedge clk);
        #1;
        checkOutput("basic_addr", 32'(next_address), 32'h0001);
        checkOutput("basic_wrap", 32'(wrapped), 32'h0);
        checkOutput("basic_addr_i2", 32'(next_address_2), 32'h0002);

        // Sequential fetches.
        applyStimulus(16'h0010);
        checkOutput("seq0_addr", 32'(next_address), 32'h0011);
        applyStimulus(16'h0011);
        checkOutput("seq1_addr", 32'(next_address), 32'h0012);
        applyStimulus(16'h0012);
        checkOutput("seq2_addr", 32'(next_address), 32'h0013);
        checkOutput("seq2_wrap", 32'(wrapped), 32'h0);

        // Boundary just below the top: no wrap for +1, wrap for +2.
        applyStimulus(16'hFFFE);
        checkOutput("fffe_addr", 32'(next_address), 32'hFFFF);
        checkOutput("fffe_wrap", 32'(wrapped), 32'h0);
        checkOutput("fffe_addr_i2", 32'(next_address_2), 32'h0000);
        checkOutput("fffe_wrap_i2", 32'(wrapped_2), 32'h1);

        // Top of address space wraps to zero.
        applyStimulus(16'hFFFF);
        checkOutput("wrap_addr", 32'(next_address), 32'h0000);
        checkOutput("wrap_wrap", 32'(wrapped), 32'h1);
        checkOutput("wrap_addr_i2", 32'(next_address_2), 32'h0001);
        checkOutput("wrap_wrap_i2", 32'(wrapped_2), 32'h1);

        applyStimulus(16'h0000);
        checkOutput("after_wrap_addr", 32'(next_address), 32'h0001);
        checkOutput("after_wrap_wrap", 32'(wrapped), 32'h0);

        applyStimulus(16'h0004);
        checkOutput("p4_addr", 32'(next_address), 32'h0005);
        checkOutput("p4_addr_i2", 32'(next_address_2), 32'h0006);
        checkOutput("p4_wrap_i2", 32'(wrapped_2), 32'h0);

        // Glitches between edges must not reach the outputs.
        applyStimulus(16'h0100);
        checkOutput("glitch_base", 32'(next_address), 32'h0101);
        #1;
        current_address = 16'h0200;
        #2;
        checkOutput("glitch_mid", 32'(next_address), 32'h0101);
        current_address = 16'h0100;
        #2;
        checkOutput("glitch_back", 32'(next_address), 32'h0101);
        @(posedge clk);
        #1;
        checkOutput("glitch_edge", 32'(next_address), 32'h0101);

        // Mid-cycle reset while wrapped is set clears both outputs at once.
        applyStimulus(16'hFFFF);
        checkOutput("pre_rst_wrap", 32'(wrapped), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_rst_addr", 32'(next_address), 32'h0000);
        checkOutput("async_rst_wrap", 32'(wrapped), 32'h0);
        checkOutput("async_rst_wrap_i2", 32'(wrapped_2), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("rst_hold_addr", 32'(next_address), 32'h0000);
        checkOutput("rst_hold_wrap", 32'(wrapped), 32'h0);

        // Release with a new address: pending sum is gone, new one loads.
        @(negedge clk);
        reset           = 1'b0;
        current_address = 16'h0ABC;
        @(posedge clk);
        #1;
        checkOutput("post_rst_addr", 32'(next_address), 32'h0ABD);
        checkOutput("post_rst_wrap", 32'(wrapped), 32'h0);
        checkOutput("post_rst_addr_i2", 32'(next_address_2), 32'h0ABE);

        applyStimulus(16'h7FFF);
        checkOutput("mid_addr", 32'(next_address), 32'h8000);
        checkOutput("mid_wrap", 32'(wrapped), 32'h0);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule : tb_pc_adder
